// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter sharing one native memory port
// (valid/ready, addr, wdata, wstrb, rdata) between NUM_REQ bus masters.
// A grant is held until the memory completes the transaction, then the
// search for the next winner starts just after the port last served.
module mem_arbiter_rr #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [DATA_WIDTH-1:0]             req_rdata,
    output logic                              mem_valid,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [DATA_WIDTH/8-1:0]           mem_wstrb,
    input  logic                              mem_ready,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic [NUM_REQ-1:0]                grant,
    output logic                              busy
);

    localparam int          SW = DATA_WIDTH / 8;
    localparam int          IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t              state;
    logic [IW-1:0]       last;
    logic [IW-1:0]       gidx;
    logic [IW-1:0]       win;
    logic [IW-1:0]       cand;
    logic                found;
    logic [NUM_REQ-1:0]  win_onehot;

    // Pick the first valid port scanning upward from last+1 with wrap
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = IW'((32'(last) + k) % NR);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // One-hot form of the winner, loaded into grant on arbitration
    always_comb begin
        win_onehot      = '0;
        win_onehot[win] = found;
    end

    // Arbitration FSM; grant, busy and last are all registered here
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            gidx  <= '0;
            last  <= IW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= BUSY;
                        grant <= win_onehot;
                        gidx  <= win;
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        last  <= gidx;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Grant is zero when idle, so the AND-OR mux drives zeros on the
    // memory side (no spurious write strobes) without a separate idle path
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            mem_addr  = mem_addr  | (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant[i]}});
            mem_wdata = mem_wdata | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
            mem_wstrb = mem_wstrb | (req_wstrb[i*SW +: SW] & {SW{grant[i]}});
        end
    end

    assign mem_valid = busy;
    assign req_ready = grant & {NUM_REQ{mem_ready}};
    assign req_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk;
    logic              resetn;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_wstrb;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     req_rdata;
    logic              mem_valid;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [SW-1:0]     mem_wstrb;
    logic              mem_ready;
    logic [DW-1:0]     mem_rdata;
    logic [N-1:0]      grant;
    logic              busy;

    int tests = 0;
    int fails = 0;

    // Reference model: is a transaction open, whose is it, who was served last
    bit m_busy;
    int m_g;
    int m_last;
    int done_q[$];

    mem_arbiter_rr #(
        .NUM_REQ   (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .req_ready(req_ready),
        .req_rdata(req_rdata),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .grant    (grant),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting port after the last one served
    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (last + k) % N;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        if (!resetn) begin
            m_busy = 0;
            m_g    = 0;
            m_last = N - 1;
        end else if (!m_busy) begin
            w = pick(req_valid, m_last);
            if (w >= 0) begin
                m_busy = 1;
                m_g    = w;
            end
        end else if (mem_ready) begin
            m_last = m_g;
            m_busy = 0;
        end
    endtask

    // One clock: check all outputs mid-cycle, then advance DUT and model
    task automatic step();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        @(negedge clk);
        eg = m_busy ? N'(1 << m_g) : '0;
        ea = m_busy ? req_addr[m_g*AW +: AW]  : '0;
        ed = m_busy ? req_wdata[m_g*DW +: DW] : '0;
        es = m_busy ? req_wstrb[m_g*SW +: SW] : '0;
        chk("grant",     64'(grant),     64'(eg));
        chk("busy",      64'(busy),      64'(m_busy));
        chk("mem_valid", 64'(mem_valid), 64'(m_busy));
        chk("mem_addr",  64'(mem_addr),  64'(ea));
        chk("mem_wdata", 64'(mem_wdata), 64'(ed));
        chk("mem_wstrb", 64'(mem_wstrb), 64'(es));
        chk("req_ready", 64'(req_ready), 64'((m_busy && mem_ready) ? eg : '0));
        chk("req_rdata", 64'(req_rdata), 64'(mem_rdata));
        if (m_busy && mem_ready && resetn) done_q.push_back(m_g);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s);
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = d;
        req_wstrb[p*SW +: SW] = s;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        req_valid = '0;
        mem_ready = 1'b0;
        step();
        step();
        resetn = 1'b1;
        done_q.delete();
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        mem_ready = 1'b0;
        mem_rdata = 32'h1234_5678;
        m_busy    = 0;
        m_g       = 0;
        m_last    = N - 1;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_grant",     64'(grant),     64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_mem_valid", 64'(mem_valid), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));

        // Single read request from port 1 with zero-wait memory
        set_port(1, 32'h100, 32'h0, 4'h0);
        req_valid = 3'b010;
        mem_ready = 1'b1;
        step();
        chk("t1_mem_valid", 64'(mem_valid), 64'(1));
        chk("t1_mem_addr",  64'(mem_addr),  64'(32'h100));
        chk("t1_req_ready", 64'(req_ready), 64'(3'b010));
        req_valid = '0;
        step();
        chk("t1_busy_after",  64'(busy),  64'(0));
        chk("t1_grant_after", 64'(grant), 64'(0));
        step();

        // All three ports request out of reset, zero-wait memory
        do_reset();
        for (int p = 0; p < N; p++) set_port(p, AW'(32'h1000 + p * 4), DW'(32'hA0 + p), 4'h0);
        req_valid = 3'b111;
        mem_ready = 1'b1;
        repeat (8) step();
        chk("t2_count", 64'(done_q.size()), 64'(4));
        if (done_q.size() == 4) begin
            chk("t2_g0", 64'(done_q[0]), 64'(0));
            chk("t2_g1", 64'(done_q[1]), 64'(1));
            chk("t2_g2", 64'(done_q[2]), 64'(2));
            chk("t2_g3", 64'(done_q[3]), 64'(0));
        end

        // Port 2 write with three wait states while the others queue up
        do_reset();
        set_port(2, 32'h200, 32'hDEAD_BEEF, 4'hF);
        req_valid = 3'b100;
        mem_ready = 1'b0;
        step();
        req_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            mem_ready = (c == 3);
            chk("t3_grant",     64'(grant),     64'(3'b100));
            chk("t3_mem_valid", 64'(mem_valid), 64'(1));
            chk("t3_mem_wdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
            chk("t3_mem_wstrb", 64'(mem_wstrb), 64'(4'hF));
            step();
        end
        req_valid = '0;
        step();
        chk("t3_count", 64'(done_q.size()), 64'(1));
        if (done_q.size() == 1) chk("t3_port", 64'(done_q[0]), 64'(2));

        // Fairness: serve port 0 alone, then ports 0 and 2 compete
        do_reset();
        req_valid = 3'b001;
        mem_ready = 1'b1;
        step();
        req_valid = '0;
        step();
        req_valid = 3'b101;
        repeat (4) step();
        chk("t4_count", 64'(done_q.size()), 64'(3));
        if (done_q.size() == 3) begin
            chk("t4_first",  64'(done_q[1]), 64'(2));
            chk("t4_second", 64'(done_q[2]), 64'(0));
        end

        // Reset pulse in the middle of a stalled transaction
        do_reset();
        req_valid = 3'b001;
        mem_ready = 1'b0;
        step();
        step();
        resetn = 1'b0;
        step();
        resetn    = 1'b1;
        req_valid = '0;
        chk("t5_grant",     64'(grant),     64'(0));
        chk("t5_mem_valid", 64'(mem_valid), 64'(0));
        chk("t5_req_ready", 64'(req_ready), 64'(0));
        chk("t5_dropped",   64'(done_q.size()), 64'(0));
        req_valid = 3'b111;
        mem_ready = 1'b1;
        repeat (2) step();
        if (done_q.size() > 0) chk("t5_restart", 64'(done_q[0]), 64'(0));
        else chk("t5_restart_count", 64'(done_q.size()), 64'(1));

        // Spurious mem_ready while idle must not move the pointer
        do_reset();
        req_valid = 3'b010;
        mem_ready = 1'b1;
        step();
        req_valid = '0;
        step();
        repeat (3) begin
            step();
            chk("t6_req_ready", 64'(req_ready), 64'(0));
            chk("t6_busy",      64'(busy),      64'(0));
        end
        req_valid = 3'b111;
        repeat (2) step();
        chk("t6_count", 64'(done_q.size()), 64'(2));
        if (done_q.size() == 2) chk("t6_next", 64'(done_q[1]), 64'(2));

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            for (int p = 0; p < N; p++) set_port(p, AW'($urandom), DW'($urandom), SW'($urandom));
            mem_ready = ($urandom_range(2) != 0);
            mem_rdata = DW'($urandom);
            resetn    = ($urandom_range(49) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
